uart_decoder: RTL and testbench

UART_DECODER -- requirements
Module: uart_decoder

---
 rtl/uart_cal_pkg.sv | 37 +++
 rtl/dec_accum.sv | 69 ++++++
 rtl/uart_decoder.sv | 130 +++++++++++++
 tb/tb_uart_decoder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cal_pkg.sv
// Shared definitions for the UART calculator: ASCII constants, opcode encoding,
// decoder state encoding and the per-byte classification record.
package uart_cal_pkg;

  localparam logic [7:0] ChSpace = 8'h20;
  localparam logic [7:0] ChStar  = 8'h2A;
  localparam logic [7:0] ChPlus  = 8'h2B;
  localparam logic [7:0] ChMinus = 8'h2D;
  localparam logic [7:0] ChSlash = 8'h2F;
  localparam logic [7:0] ChZero  = 8'h30;
  localparam logic [7:0] ChNine  = 8'h39;
  localparam logic [7:0] ChEq    = 8'h3D;

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpSub = 2'b01,
    OpMul = 2'b10,
    OpDiv = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StOpa  = 3'd1,
    StOpb  = 3'd2,
    StDone = 3'd3,
    StErr  = 3'd4
  } dec_state_e;

  typedef struct packed {
    logic    digit;
    logic    op;
    logic    eq;
    logic    space;
    opcode_e opc;
  } char_class_t;

endpackage

// File: rtl/dec_accum.sv
// Byte classifier plus one decimal operand accumulator (acc*10 + digit, mod 2^32)
// with a digit counter used to enforce the per-operand digit limit.
module dec_accum
  import uart_cal_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        clr,
  input  logic        add,
  output char_class_t cls,
  output logic [31:0] acc,
  output logic        full,
  output logic        empty
);

  localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);

  logic [31:0]     acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cls       = '0;
    cls.opc   = OpAdd;
    cls.digit = (rx_data >= ChZero) && (rx_data <= ChNine);
    cls.eq    = (rx_data == ChEq);
    cls.space = (rx_data == ChSpace);
    case (rx_data)
      ChPlus:  begin cls.op = 1'b1; cls.opc = OpAdd; end
      ChMinus: begin cls.op = 1'b1; cls.opc = OpSub; end
      ChStar:  begin cls.op = 1'b1; cls.opc = OpMul; end
      ChSlash: begin cls.op = 1'b1; cls.opc = OpDiv; end
      default: ;
    endcase
  end

  // clr and add together load the first digit of a fresh operand.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end
    if (add) begin
      acc_d = acc_d * 32'd10 + {28'd0, rx_data[3:0]};
      cnt_d = cnt_d + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    acc   = acc_q;
    full  = (cnt_q == CntW'(MAX_DIGITS));
    empty = (cnt_q == '0);
  end

endmodule

// File: rtl/uart_decoder.sv
// Parses "<digits> <op> <digits> =" byte streams into ALU operands and opcode,
// pulsing dec_done on success or dec_err once a malformed expression is terminated.
module uart_decoder
  import uart_cal_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        uin_valid,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [1:0]  opcode,
  output logic        dec_done,
  output logic        dec_err
);

  dec_state_e  state_q;
  opcode_e     opc_q;
  char_class_t cls_a, cls_b, cls;
  logic [31:0] acc_a, acc_b;
  logic        full_a, full_b, empty_a, empty_b;
  logic        accept, clr, add_a, add_b;

  // Each operand's classifier serves the phase that feeds its accumulator.
  always_comb begin
    cls    = (state_q == StOpb) ? cls_b : cls_a;
    accept = uin_valid && cls.digit;
    clr    = accept && (state_q == StIdle);
    add_a  = accept && ((state_q == StIdle) || ((state_q == StOpa) && !full_a));
    add_b  = accept && (state_q == StOpb) && !full_b;
  end

  dec_accum #(
    .MAX_DIGITS(MAX_DIGITS)
  ) u_acc_a (
    .clk    (clk),
    .rst    (rst),
    .rx_data(rx_data),
    .clr    (clr),
    .add    (add_a),
    .cls    (cls_a),
    .acc    (acc_a),
    .full   (full_a),
    .empty  (empty_a)
  );

  dec_accum #(
    .MAX_DIGITS(MAX_DIGITS)
  ) u_acc_b (
    .clk    (clk),
    .rst    (rst),
    .rx_data(rx_data),
    .clr    (clr),
    .add    (add_b),
    .cls    (cls_b),
    .acc    (acc_b),
    .full   (full_b),
    .empty  (empty_b)
  );

  // An '=' that itself makes the expression malformed terminates it at once,
  // so dec_err still follows that '=' by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      opc_q    <= OpAdd;
      op_a     <= '0;
      op_b     <= '0;
      opcode   <= '0;
      dec_done <= 1'b0;
      dec_err  <= 1'b0;
    end else begin
      dec_done <= 1'b0;
      dec_err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (uin_valid && !cls.space) begin
            if (cls.digit)   state_q <= StOpa;
            else if (cls.eq) dec_err <= 1'b1;
            else             state_q <= StErr;
          end
        end
        StOpa: begin
          if (uin_valid && !cls.space) begin
            if (cls.digit && !full_a) begin
              state_q <= StOpa;
            end else if (cls.op && !empty_a) begin
              state_q <= StOpb;
              opc_q   <= cls.opc;
            end else if (cls.eq) begin
              state_q <= StIdle;
              dec_err <= 1'b1;
            end else begin
              state_q <= StErr;
            end
          end
        end
        StOpb: begin
          if (uin_valid && !cls.space) begin
            if (cls.digit && !full_b) begin
              state_q <= StOpb;
            end else if (cls.eq && !empty_b) begin
              state_q  <= StDone;
              dec_done <= 1'b1;
              op_a     <= acc_a;
              op_b     <= acc_b;
              opcode   <= opc_q;
            end else if (cls.eq) begin
              state_q <= StIdle;
              dec_err <= 1'b1;
            end else begin
              state_q <= StErr;
            end
          end
        end
        StDone: state_q <= StIdle;
        StErr: begin
          if (uin_valid && cls.eq) begin
            state_q <= StIdle;
            dec_err <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_decoder.sv
// Scoreboard bench for uart_decoder: a grammar-level model predicts each
// expression's outcome; a negedge monitor pops and checks every pulse.
module tb_uart_decoder;
  import uart_cal_pkg::*;

  localparam int MaxDigits = 10;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    bit          done;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        uin_valid = 1'b0;
  logic [31:0] op_a, op_b;
  logic [1:0]  opcode;
  logic        dec_done, dec_err;

  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  exp_t        exp_q[$];
  logic [31:0] held_a = '0;
  logic [31:0] held_b = '0;
  logic [1:0]  held_op = '0;

  uart_decoder #(
    .MAX_DIGITS(MaxDigits)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .uin_valid(uin_valid),
    .op_a     (op_a),
    .op_b     (op_b),
    .opcode   (opcode),
    .dec_done (dec_done),
    .dec_err  (dec_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Grammar model: strip spaces, then <1..Max digits> <op> <1..Max digits> '='.
  function automatic void model(input bq_t s, output bit ok, output logic [31:0] a,
                                output logic [31:0] b, output logic [1:0] op);
    bq_t t;
    int  i = 0;
    int  na = 0;
    int  nb = 0;
    ok = 0; a = 0; b = 0; op = 0;
    foreach (s[k]) if (s[k] != 8'h20) t.push_back(s[k]);
    while (i < t.size() && t[i] >= 8'h30 && t[i] <= 8'h39) begin
      a = a * 10 + 32'(t[i] - 8'h30);
      na++;
      i++;
    end
    if (na < 1 || na > MaxDigits || i >= t.size()) return;
    case (t[i])
      8'h2B: op = 2'd0;
      8'h2D: op = 2'd1;
      8'h2A: op = 2'd2;
      8'h2F: op = 2'd3;
      default: return;
    endcase
    i++;
    while (i < t.size() && t[i] >= 8'h30 && t[i] <= 8'h39) begin
      b = b * 10 + 32'(t[i] - 8'h30);
      nb++;
      i++;
    end
    if (nb < 1 || nb > MaxDigits) return;
    if (i == t.size() - 1 && t[i] == 8'h3D) ok = 1;
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bq_t put(input bq_t q, input logic [7:0] c);
    bq_t r = q;
    if ($urandom_range(0, 5) == 0) r.push_back(8'h20);
    r.push_back(c);
    return r;
  endfunction

  // Kinds: 0-2 valid, 3 missing A, 4 stray letter, 5 missing B, 6 A too long.
  function automatic bq_t gen_expr();
    bq_t        q;
    int         kind = $urandom_range(0, 6);
    int         na = (kind == 6) ? MaxDigits + 1 : $urandom_range(1, MaxDigits);
    int         nb = $urandom_range(1, MaxDigits);
    logic [7:0] ops[4] = '{8'h2B, 8'h2D, 8'h2A, 8'h2F};
    if (kind != 3)
      for (int i = 0; i < na; i++) q = put(q, 8'h30 + 8'($urandom_range(0, 9)));
    if (kind == 4) q = put(q, 8'h41 + 8'($urandom_range(0, 25)));
    q = put(q, ops[$urandom_range(0, 3)]);
    if (kind != 5)
      for (int i = 0; i < nb; i++) q = put(q, 8'h30 + 8'($urandom_range(0, 9)));
    q = put(q, 8'h3D);
    return q;
  endfunction

  task automatic expect_eq(input bit ok, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op);
    exp_t e;
    if (ok) begin
      held_a = a; held_b = b; held_op = op;
    end
    e.done = ok; e.a = held_a; e.b = held_b; e.op = held_op; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic send_str(input bq_t s);
    bit          ok;
    logic [31:0] a, b;
    logic [1:0]  op;
    model(s, ok, a, b, op);
    foreach (s[k]) begin
      rx_data = s[k];
      uin_valid = 1'b1;
      @(posedge clk);
      #1;
      uin_valid = 1'b0;
      if (s[k] == 8'h3D) expect_eq(ok, a, b, op);
      repeat ($urandom_range(1, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    held_a = '0; held_b = '0; held_op = '0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (dec_done && dec_err) check("done_err_exclusive", 32'd1, 32'd0);
    if (dec_done || dec_err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_is_done", 32'(dec_done), 32'(e.done));
        check("pulse_latency", cyc, e.cyc);
        check("op_a", op_a, e.a);
        check("op_b", op_b, e.b);
        check("opcode", 32'(opcode), 32'(e.op));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_op_a", op_a, 32'd0);
    check("reset_op_b", op_b, 32'd0);
    check("reset_opcode", 32'(opcode), 32'd0);
    check("reset_done", 32'(dec_done), 32'd0);
    check("reset_err", 32'(dec_err), 32'd0);

    // Start operand A, then reset together with a valid digit byte.
    rx_data = 8'h33;
    uin_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_data = 8'h35;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    uin_valid = 1'b0;
    check("rst_vs_valid_state", 32'(dut.state_q), 32'(StIdle));
    check("rst_vs_valid_acc_a", dut.u_acc_a.acc_q, 32'd0);
    check("rst_vs_valid_acc_b", dut.u_acc_b.acc_q, 32'd0);
    @(posedge clk);
    #1;

    send_str(str2q("12+34="));
    send_str(str2q("123 * 45 ="));
    send_str(str2q("4294967296/7="));
    send_str(str2q("12345678901+1="));
    send_str(str2q("+5="));
    send_str(str2q("9U3="));
    send_str(str2q("8-="));

    send_str(str2q("12+"));
    pulse_reset();
    check("midexpr_reset_op_b", op_b, 32'd0);
    check("midexpr_reset_opcode", 32'(opcode), 32'd0);
    send_str(str2q("7-3="));

    // A byte arriving in the DONE cycle must be ignored.
    send_str(str2q("1+1"));
    rx_data = 8'h3D;
    uin_valid = 1'b1;
    @(posedge clk);
    #1;
    expect_eq(1'b1, 32'd1, 32'd1, 2'd0);
    rx_data = 8'h39;
    @(posedge clk);
    #1;
    uin_valid = 1'b0;
    @(posedge clk);
    #1;
    send_str(str2q("2*3="));

    for (int n = 0; n < 60; n++) send_str(gen_expr());

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("pending_expectations", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
